// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: mode encodings,
// fill-counter width helper and parameter legality checks.
package seq_det_pkg;

    typedef enum logic {
        OVERLAP_OFF = 1'b0,
        OVERLAP_ON  = 1'b1
    } overlap_e;

    typedef enum logic {
        OUT_MOORE = 1'b0,
        OUT_MEALY = 1'b1
    } out_mode_e;

    localparam int LEN_MIN = 1;
    localparam int LEN_MAX = 16;

    // Width needed to hold a fill count in the range 0..len.
    function automatic int fill_w(input int len);
        return $clog2(len + 1);
    endfunction

    function automatic bit len_ok(input int len);
        return (len >= LEN_MIN) && (len <= LEN_MAX);
    endfunction

    // The pattern must not carry set bits above the pattern length.
    function automatic bit pat_ok(input int len, input logic [15:0] pat);
        return (32'(pat) >> len) == 32'd0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and soft clear.
// Ports: CLK, reset, clr, inc -> count (W bits), sat (count at max).
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign sat   = &count_q;
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (inc && !sat) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset || clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector built on a shift history plus fill count.
// Ports: CLK, reset, clear, in_valid, in -> out, hit_count, count_sat.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int          LEN     = 2,
    parameter logic [15:0] PATTERN = 16'b11,
    parameter int          OVERLAP = 1,
    parameter int          MEALY   = 0,
    parameter int          CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in,
    output logic             out,
    output logic [CNT_W-1:0] hit_count,
    output logic             count_sat
);

    localparam int FW = fill_w(LEN);
    localparam logic [FW-1:0]  LEN_F = FW'(LEN);
    localparam logic [LEN-1:0] PAT   = PATTERN[LEN-1:0];
    localparam overlap_e  OVL_MODE =
        (OVERLAP != 0) ? OVERLAP_ON : OVERLAP_OFF;
    localparam out_mode_e OUT_MODE =
        (MEALY != 0) ? OUT_MEALY : OUT_MOORE;

    if (!len_ok(LEN) || !pat_ok(LEN, PATTERN)) begin : g_bad_param
        $error("seq_detector: illegal LEN or PATTERN");
    end

    logic [LEN-1:0] hist_q;
    logic [LEN-1:0] hist_d;
    logic [LEN-1:0] hist_nx;
    logic [FW-1:0]  fill_q;
    logic [FW-1:0]  fill_d;
    logic [FW-1:0]  fill_nx;
    logic           out_q;
    logic           out_d;
    logic           match_raw;
    logic           match;

    if (LEN == 1) begin : g_hist1
        assign hist_nx = in;
    end else begin : g_histn
        assign hist_nx = {hist_q[LEN-2:0], in};
    end

    assign fill_nx = (fill_q == LEN_F) ? fill_q : fill_q + FW'(1);

    // A full, matching history only counts if this bit survives the
    // edge; a clear or reset on the same edge discards it.
    assign match_raw = in_valid && (fill_nx == LEN_F) && (hist_nx == PAT);
    assign match     = match_raw && !clear && !reset;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        out_d  = match;
        if (in_valid) begin
            hist_d = hist_nx;
            if (match && (OVL_MODE == OVERLAP_OFF)) begin
                fill_d = '0;
            end else begin
                fill_d = fill_nx;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset || clear) begin
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
        end
    end

    assign out = (OUT_MODE == OUT_MEALY) ? match : out_q;

    sat_counter #(
        .W(CNT_W)
    ) u_hits (
        .CLK  (CLK),
        .reset(reset),
        .clr  (clear),
        .inc  (match),
        .count(hit_count),
        .sat  (count_sat)
    );

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 SHALL have parameter LEN, default 2, meaning pattern length in bits (legal 1..16).
REQ-002 SHALL have parameter PATTERN, default 2'b11, meaning LEN-bit target; the oldest bit is the MSB, the newest bit is the LSB.
REQ-003 SHALL have parameter OVERLAP, default 1, meaning 1 = matches may share bits, 0 = history restarts after each match.
REQ-004 SHALL have parameter MEALY, default 0, meaning 0 = registered (Moore) out, 1 = combinational (Mealy) out.
REQ-005 SHALL have parameter CNT_W, default 8, meaning hit counter width.
REQ-006 SHALL have port CLK, input, 1 bit: clock; all state updates on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port clear, input, 1 bit: synchronous soft clear of all state.
REQ-009 SHALL have port in_valid, input, 1 bit: in is accepted on this edge.
REQ-010 SHALL have port in, input, 1 bit: serial data bit.
REQ-011 SHALL have port out, output, 1 bit: match indication.
REQ-012 SHALL have port hit_count, output, CNT_W bits: number of matches, saturating.
REQ-013 SHALL have port count_sat, output, 1 bit: hit_count is at its maximum of 2^CNT_W-1.

Function
REQ-014 SHALL hold the history register hist[LEN-1:0] and the fill counter fill (0..LEN).
REQ-015 Accepted bit: hist_next = {hist[LEN-2:0], in}; for LEN=1, hist_next = in.
REQ-016 Accepted bit: fill_next = min(fill+1, LEN).
REQ-017 Idle cycle (in_valid=0): hist and fill SHALL hold.
REQ-018 SHALL compute match = in_valid AND fill_next==LEN AND hist_next==PATTERN.
REQ-019 If match AND OVERLAP=0, fill SHALL load 0 instead of fill_next; hist still loads hist_next.
REQ-020 MEALY=0: out_q SHALL load match on every edge; out = out_q.
  - out is high exactly the cycle after the completing bit.
  - out is low on any cycle following an idle cycle.
REQ-021 MEALY=1: out = match, combinational in the same cycle as the completing bit; no register in the path.
REQ-022 On each match, hit_count SHALL increment by 1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - count_sat = (hit_count == 2^CNT_W-1).
REQ-023 Until fill reaches LEN, no match SHALL occur; partial history never matches.
REQ-024 clear=1 SHALL zero hist, fill, out_q and hit_count on that edge.
  - The same-cycle in bit is discarded and not counted.
  - In MEALY=1 mode, out SHALL be forced 0 while clear=1.
REQ-025 reset SHALL take priority over clear; clear SHALL take priority over in_valid.
REQ-026 Continuous run with PATTERN all-ones and OVERLAP=1: out SHALL stay high on every cycle after the LENth consecutive accepted 1 until a 0 is accepted.

Reset
REQ-027 On reset=1 at an edge: hist=0, fill=0, out_q=0, hit_count=0, count_sat=0.
REQ-028 Reset asserted mid-sequence SHALL discard partial history; detection restarts from an empty history.
REQ-029 No state SHALL be asynchronous; all outputs are defined from the first edge with reset=1.

Structure
REQ-030 Mode encodings SHALL live in shared package seq_det_pkg, together with the fill width function clog2(LEN+1) and parameter-legality checks (LEN range, PATTERN width).
  - Mode encodings: OVERLAP_ON/OFF, OUT_MOORE/MEALY.
REQ-031 The saturating counter SHALL be the sub-module sat_counter (params W; ports CLK, reset, clr, inc, count, sat); it is reused for hit_count.
REQ-032 The detector SHALL not be coded as an explicit state case; hist/fill comparison replaces the per-pattern state table.

Verification
REQ-033 Defaults; reset 1 cycle, then accepted in = 0,1,1,1,0 -> out (Moore) = 0,0,1,1,0 one cycle delayed; hit_count=2.
REQ-034 LEN=3, PATTERN=3'b101, OVERLAP=1 vs 0; in = 1,0,1,0,1 -> hit_count=2 (overlap) vs 1 (non-overlap).
REQ-035 MEALY=1, defaults; in = 1,1 -> out high combinationally during the second bit's cycle, before its edge.
REQ-036 Defaults; in = 1, then in_valid=0 for 3 cycles, then in = 1 -> match on the second accepted bit; out low during idle cycles.
REQ-037 CNT_W=2, 5 matches -> hit_count = 0,1,2,3,3; count_sat goes high at 3 and stays high.
REQ-038 Sequence 1,[clear with in=1],1 -> no match, hit_count=0. Repeat with reset asserted mid-run -> identical result.
